uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver. It is the next-generation serial input stage of the UART subsystem. It synchronises the asynchronous line, locates the start bit with a mid-bit oversampled check, and shifts in a configurable number of data bits. It can optionally check parity, validates one or two stop bits, and presents each word through a valid/ready holding register that reports error and overrun status to the downstream command/ASCII decoder.

---
 rtl/uart_rx_os.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a valid/ready holding register and error/overrun status.
// Define UART_RX_PARITY_EN to expect and check one parity bit after the data bits.
module uart_rx_os #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun
);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TCK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
      (OVERSAMPLE % 2) != 0 || CLK_DIV < 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
      ODD_PARITY > 1) begin : g_bad_params
    $error("uart_rx_os: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [TCK_W-1:0]     tck_q, tck_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_f_q, perr_f_d;
  logic                 ferr_f_q, ferr_f_d;
  logic                 s1_q, rxs_q;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, sample, mid, load, accept;

  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  assign sample = tick && (tck_q == TCK_W'(OVERSAMPLE - 1));
  assign mid    = tick && (tck_q == TCK_W'(OVERSAMPLE / 2 - 1));
  assign accept = valid_q & rx_ready;

  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    tck_d    = tck_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    perr_f_d = perr_f_q;
    ferr_f_d = ferr_f_q;
    load     = 1'b0;
    if (tick) tck_d = sample ? '0 : tck_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          div_d   = '0;
          tck_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (mid) begin
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            tck_d    = '0;
            bit_d    = '0;
            stop_d   = 1'b0;
            perr_f_d = 1'b0;
            ferr_f_d = 1'b0;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        // Shifting in from the top leaves bit 0 in shift[0] after DATA_BITS samples.
        if (sample) begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample) begin
          perr_f_d = rxs_q ^ (^shift_q) ^ 1'(ODD_PARITY);
          state_d  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sample) begin
          ferr_f_d = ferr_f_q | ~rxs_q;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            load    = 1'b1;
            state_d = rxs_q ? S_IDLE : S_WAIT_HIGH;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    byte_d  = byte_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = valid_q & ~accept;
    ovr_d   = ovr_q & ~accept;
    // A slot freed by this cycle's handshake can take the new word immediately.
    if (load) begin
      if (!valid_q || accept) begin
        byte_d  = shift_q;
        perr_d  = perr_f_q;
        ferr_d  = ferr_f_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= 1'b1;
      rxs_q    <= 1'b1;
      state_q  <= S_IDLE;
      div_q    <= '0;
      tck_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      perr_f_q <= 1'b0;
      ferr_f_q <= 1'b0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= rx_data;
      rxs_q    <= s1_q;
      state_q  <= state_d;
      div_q    <= div_d;
      tck_q    <= tck_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      perr_f_q <= perr_f_d;
      ferr_f_q <= ferr_f_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx_byte      = byte_q;
  assign rx_valid     = valid_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: frame-level receiver model compared every cycle,
// plus directed frames with literal expectations. Parity cases run when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int unsigned DB   = 8;
  localparam int unsigned OS   = 16;
  localparam int unsigned CD   = 1;
  localparam int unsigned SB   = 1;
  localparam int unsigned ODDP = 0;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned LAT = 156 + 16 * PAR + 16 * (SB - 1);

  logic clk = 1'b0;
  logic reset, rx_data, rx_ready;
  logic [DB-1:0] rx_byte;
  logic rx_valid, parity_error, frame_error, overrun;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned nneg = 0;

  typedef struct {
    logic [DB-1:0] b;
    logic          pe;
    logic          fe;
    int unsigned   cyc;
  } rec_t;
  rec_t recq[$];

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_BITS(DB), .OVERSAMPLE(OS), .CLK_DIV(CD), .STOP_BITS(SB), .ODD_PARITY(ODDP)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: edges counted from start detection, samples at OS/2 + k*OS.
  localparam int M_IDLE = 0, M_FRAME = 1, M_WAIT = 2;
  int mm;
  int unsigned ed;
  logic ln1, ln2, live;
  logic [DB-1:0] m_word;
  logic m_perr, m_ferr;
  logic [DB-1:0] e_byte;
  logic e_valid, e_perr, e_ferr, e_ovr;

  initial begin
    int unsigned j;
    logic s, acc, ld, oldv;
    live = 1'b0;
    mm = M_IDLE; ed = 0; ln1 = 1'b1; ln2 = 1'b1;
    m_word = '0; m_perr = 1'b0; m_ferr = 1'b0;
    e_byte = '0; e_valid = 1'b0; e_perr = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
    forever begin
      @(posedge clk);
      s = ln2;
      if (!reset) begin
        mm = M_IDLE; ed = 0; ln1 = 1'b1; ln2 = 1'b1;
        e_byte = '0; e_valid = 1'b0; e_perr = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
        live = 1'b1;
      end else begin
        ld = 1'b0;
        case (mm)
          M_IDLE: if (!s) begin
            mm = M_FRAME; ed = 0; m_word = '0; m_perr = 1'b0; m_ferr = 1'b0;
          end
          M_FRAME: begin
            ed++;
            if (ed >= OS / 2 && ((ed - OS / 2) % OS) == 0) begin
              j = (ed - OS / 2) / OS;
              if (j == 0) begin
                if (s) mm = M_IDLE;
              end else if (j <= DB) begin
                m_word[j-1] = s;
              end else if (PAR != 0 && j == DB + 1) begin
                m_perr = s ^ (^m_word) ^ (ODDP != 0);
              end else begin
                if (!s) m_ferr = 1'b1;
                if (j == DB + PAR + SB) begin
                  ld = 1'b1;
                  mm = s ? M_IDLE : M_WAIT;
                end
              end
            end
          end
          default: if (s) mm = M_IDLE;
        endcase
        oldv = e_valid;
        acc = e_valid & rx_ready;
        if (acc) begin e_valid = 1'b0; e_ovr = 1'b0; end
        if (ld) begin
          if (!oldv || acc) begin
            e_byte = m_word; e_perr = m_perr; e_ferr = m_ferr; e_valid = 1'b1;
          end else begin
            e_ovr = 1'b1;
          end
        end
        ln2 = ln1;
        ln1 = rx_data;
      end
    end
  end

  // Compare process plus delivery recorder.
  initial begin
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      nneg++;
      if (live) begin
        chk("rx_valid", rx_valid, e_valid);
        chk("rx_byte", rx_byte, e_byte);
        chk("parity_error", parity_error, e_perr);
        chk("frame_error", frame_error, e_ferr);
        chk("overrun", overrun, e_ovr);
      end
      if (rx_valid === 1'b1 && !pv) recq.push_back('{rx_byte, parity_error, frame_error, nneg});
      pv = (rx_valid === 1'b1);
    end
  end

  task automatic idle(input int unsigned n);
    rx_data = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input logic stop_v,
                            input int unsigned rst_at, output int unsigned t_start);
    logic bits[$];
    int unsigned c;
    c = 0;
    bits.push_back(1'b0);
    for (int unsigned i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PAR != 0) bits.push_back((^d) ^ (ODDP != 0) ^ bad_par);
    for (int unsigned i = 0; i < SB; i++) bits.push_back(stop_v);
    t_start = nneg;
    foreach (bits[k]) begin
      rx_data = bits[k];
      for (int unsigned t = 0; t < OS; t++) begin
        reset = !(rst_at != 0 && c == rst_at);
        @(posedge clk);
        #1;
        c++;
      end
    end
    reset = 1'b1;
    rx_data = 1'b1;
  endtask

  task automatic chk_rec(input string nm, input int unsigned n0, input logic [DB-1:0] b,
                         input logic pe, input logic fe);
    chk({nm, "_count"}, recq.size(), n0 + 1);
    if (recq.size() > n0) begin
      chk({nm, "_byte"}, recq[n0].b, b);
      chk({nm, "_perr"}, recq[n0].pe, pe);
      chk({nm, "_ferr"}, recq[n0].fe, fe);
    end
  endtask

  initial begin
    int unsigned n0, ts;
    reset = 1'b0; rx_data = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_byte", rx_byte, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b1;
    idle(20);

    // Clean frame with latency pinned.
    n0 = recq.size();
    send_frame(8'h5A, 1'b0, 1'b1, 0, ts);
    idle(20);
    chk_rec("clean5A", n0, 8'h5A, 1'b0, 1'b0);
    if (recq.size() > n0) chk("clean5A_latency", recq[n0].cyc - ts, LAT);
    chk("clean5A_pulse", rx_valid, 0);

    // Glitch, then a real frame.
    n0 = recq.size();
    rx_data = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    chk("glitch_count", recq.size(), n0);
    send_frame(8'hA5, 1'b0, 1'b1, 0, ts);
    idle(20);
    chk_rec("afterglitchA5", n0, 8'hA5, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    n0 = recq.size();
    send_frame(8'h07, 1'b1, 1'b1, 0, ts);
    idle(20);
    chk_rec("par07bad", n0, 8'h07, 1'b1, 1'b0);
    n0 = recq.size();
    send_frame(8'h07, 1'b0, 1'b1, 0, ts);
    idle(20);
    chk_rec("par07ok", n0, 8'h07, 1'b0, 1'b0);
`endif

    // Stop bit low, then a 40-bit break.
    n0 = recq.size();
    send_frame(8'h33, 1'b0, 1'b0, 0, ts);
    idle(20);
    chk_rec("stoplow33", n0, 8'h33, 1'b0, 1'b1);
    n0 = recq.size();
    rx_data = 1'b0;
    repeat (40 * OS) @(posedge clk);
    #1;
    idle(60);
    chk_rec("break", n0, 8'h00, 1'b0, 1'b1);

    // Overrun with back-to-back frames.
    rx_ready = 1'b0;
    n0 = recq.size();
    send_frame(8'h11, 1'b0, 1'b1, 0, ts);
    send_frame(8'h22, 1'b0, 1'b1, 0, ts);
    idle(20);
    chk_rec("ovr11", n0, 8'h11, 1'b0, 1'b0);
    chk("ovr_byte", rx_byte, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_flag", overrun, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    chk("ovr_clr_valid", rx_valid, 0);
    chk("ovr_clr_flag", overrun, 0);
    chk("ovr_hold_byte", rx_byte, 8'h11);
    idle(5);
    rx_ready = 1'b1;

    // Reset during data bit 4.
    n0 = recq.size();
    send_frame(8'hFF, 1'b0, 1'b1, 88, ts);
    idle(40);
    chk("rstmid_count", recq.size(), n0);
    chk("rstmid_byte", rx_byte, 0);
    chk("rstmid_valid", rx_valid, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 0, ts);
    idle(20);
    chk_rec("after_rst3C", n0, 8'h3C, 1'b0, 1'b0);

    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
